// File: rtl/mmu_arbiter_wrr_pkg.sv
// mmu_arbiter_wrr_pkg: default widths shared by the WRR DMA arbiter and its ordering FIFO,
// plus the modular index helper used by the round-robin search.
package mmu_arbiter_wrr_pkg;
  localparam int N_CH_DEF      = 4;
  localparam int REQ_BITS_DEF  = 128;
  localparam int LEN_BITS_DEF  = 28;
  localparam int W_BITS_DEF    = 4;
  localparam int OUT_BITS_DEF  = 4;
  localparam int ORD_DEPTH_DEF = 16;
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/mmu_ord_fifo.sv
// mmu_ord_fifo: synchronous FIFO holding the {id,len} grant order for the data-path mux.
module mmu_ord_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge aclk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/mmu_arbiter_wrr.sv
// mmu_arbiter_wrr: weighted round-robin DMA request arbiter with per-channel outstanding caps,
// completion tracking and an ordering FIFO that steers the data-path mux.
module mmu_arbiter_wrr
  import mmu_arbiter_wrr_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int REQ_BITS  = REQ_BITS_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF,
  parameter int W_BITS    = W_BITS_DEF,
  parameter int OUT_BITS  = OUT_BITS_DEF,
  parameter int ORD_DEPTH = ORD_DEPTH_DEF
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_CH*W_BITS-1:0]     cfg_weight,
  input  logic [OUT_BITS-1:0]        cfg_max_out,
  input  logic [N_CH-1:0]            s_req_valid,
  output logic [N_CH-1:0]            s_req_ready,
  input  logic [N_CH*REQ_BITS-1:0]   s_req_data,
  input  logic [N_CH*LEN_BITS-1:0]   s_req_len,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,
  output logic [REQ_BITS-1:0]        m_req_data,
  output logic                       m_mux_valid,
  input  logic                       m_mux_ready,
  output logic [$clog2(N_CH)-1:0]    m_mux_id,
  output logic [LEN_BITS-1:0]        m_mux_len,
  input  logic                       s_done_valid,
  input  logic [$clog2(N_CH)-1:0]    s_done_id,
  output logic [N_CH*OUT_BITS-1:0]   out_cnt,
  output logic                       err_underflow
);
  localparam int IDW = $clog2(N_CH);
  typedef struct packed {
    logic [IDW-1:0]      id;
    logic [LEN_BITS-1:0] len;
  } ord_t;
  logic [IDW-1:0]      rr_ptr, nxt_ptr, gnt_id;
  logic [W_BITS-1:0]   credit, nxt_credit;
  logic                gnt, fifo_full, fifo_empty, slot_free;
  logic [OUT_BITS-1:0] cap;
  logic [N_CH-1:0]     elig, done_vec;
  ord_t                ord_in, ord_out;
  function automatic logic [W_BITS-1:0] wt(input int c);
    return cfg_weight[c*W_BITS +: W_BITS];
  endfunction
  assign cap       = cfg_max_out == '0 ? '1 : cfg_max_out;
  assign slot_free = !m_req_valid || m_req_ready;
  assign done_vec  = s_done_valid ? N_CH'(1) << s_done_id : '0;
  // Reset gates eligibility so no ready leaks out while the block is held in reset.
  always_comb begin
    elig = '0;
    for (int c = 0; c < N_CH; c++)
      elig[c] = aresetn && s_req_valid[c] && wt(c) != '0 &&
                out_cnt[c*OUT_BITS +: OUT_BITS] < cap && !fifo_full && slot_free;
  end
  always_comb begin
    gnt        = 1'b0;
    gnt_id     = rr_ptr;
    nxt_ptr    = rr_ptr;
    nxt_credit = credit;
    if (elig[rr_ptr] && credit != '0) begin
      gnt        = 1'b1;
      nxt_credit = credit - 1'b1;
    end else
      for (int i = 1; i <= N_CH; i++)
        if (!gnt && elig[wrap_add(int'(rr_ptr), i, N_CH)]) begin
          gnt        = 1'b1;
          gnt_id     = IDW'(wrap_add(int'(rr_ptr), i, N_CH));
          nxt_ptr    = IDW'(wrap_add(int'(rr_ptr), i, N_CH));
          nxt_credit = wt(wrap_add(int'(rr_ptr), i, N_CH)) - 1'b1;
        end
  end
  assign s_req_ready = gnt ? N_CH'(1) << gnt_id : '0;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rr_ptr        <= IDW'(N_CH-1);
      credit        <= '0;
      m_req_valid   <= 1'b0;
      m_req_data    <= '0;
      out_cnt       <= '0;
      err_underflow <= 1'b0;
    end else begin
      rr_ptr <= nxt_ptr;
      credit <= nxt_credit;
      if (gnt) begin
        m_req_valid <= 1'b1;
        m_req_data  <= s_req_data[int'(gnt_id)*REQ_BITS +: REQ_BITS];
      end else if (m_req_ready) m_req_valid <= 1'b0;
      // A grant and a completion on the same channel cancel out.
      for (int c = 0; c < N_CH; c++)
        if (s_req_ready[c] && !done_vec[c])
          out_cnt[c*OUT_BITS +: OUT_BITS] <= out_cnt[c*OUT_BITS +: OUT_BITS] + 1'b1;
        else if (done_vec[c] && !s_req_ready[c]) begin
          if (out_cnt[c*OUT_BITS +: OUT_BITS] == '0) err_underflow <= 1'b1;
          else out_cnt[c*OUT_BITS +: OUT_BITS] <= out_cnt[c*OUT_BITS +: OUT_BITS] - 1'b1;
        end
    end
  assign ord_in.id  = gnt_id;
  assign ord_in.len = s_req_len[int'(gnt_id)*LEN_BITS +: LEN_BITS];
  mmu_ord_fifo #(.W($bits(ord_t)), .DEPTH(ORD_DEPTH)) u_ord (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (gnt),
    .din     (ord_in),
    .pop     (m_mux_valid && m_mux_ready),
    .dout    (ord_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
  assign m_mux_valid = !fifo_empty;
  assign m_mux_id    = m_mux_valid ? ord_out.id : '0;
  assign m_mux_len   = m_mux_valid ? ord_out.len : '0;
endmodule

// File: tb/tb_mmu_arbiter_wrr.sv
// tb_mmu_arbiter_wrr: directed and random checks of the WRR arbiter against a queue-based model.
module tb_mmu_arbiter_wrr;
  localparam int N = 4, RB = 128, LB = 28, WB = 4, OB = 4, D = 16;
  logic            aclk = 1'b0, aresetn = 1'b0;
  logic [N*WB-1:0] cfg_weight = '0;
  logic [OB-1:0]   cfg_max_out = '0;
  logic [N-1:0]    s_req_valid = '0, s_req_ready;
  logic [N*RB-1:0] s_req_data = '0;
  logic [N*LB-1:0] s_req_len = '0;
  logic            m_req_valid, m_req_ready = 1'b0;
  logic [RB-1:0]   m_req_data;
  logic            m_mux_valid, m_mux_ready = 1'b0;
  logic [1:0]      m_mux_id;
  logic [LB-1:0]   m_mux_len;
  logic            s_done_valid = 1'b0;
  logic [1:0]      s_done_id = '0;
  logic [N*OB-1:0] out_cnt;
  logic            err_underflow;
  int n_assert = 0, n_fail = 0;
  int mcnt[N];
  int mptr, mcred;
  bit mv, merr;
  logic [RB-1:0] md;
  logic [LB+1:0] mq[$];

  mmu_arbiter_wrr dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_weight(cfg_weight), .cfg_max_out(cfg_max_out),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .s_req_len(s_req_len), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_data(m_req_data), .m_mux_valid(m_mux_valid), .m_mux_ready(m_mux_ready),
    .m_mux_id(m_mux_id), .m_mux_len(m_mux_len), .s_done_valid(s_done_valid),
    .s_done_id(s_done_id), .out_cnt(out_cnt), .err_underflow(err_underflow)
  );

  initial forever #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wgt(input int c);
    return int'(cfg_weight[c*WB +: WB]);
  endfunction

  task automatic model_reset();
    foreach (mcnt[c]) mcnt[c] = 0;
    mptr = N - 1; mcred = 0; mv = 0; merr = 0; md = '0;
    mq.delete();
  endtask

  task automatic rand_data();
    for (int c = 0; c < N; c++) begin
      s_req_data[c*RB +: RB] = {$urandom, $urandom, $urandom, $urandom};
      s_req_len[c*LB +: LB]  = LB'($urandom);
    end
  endtask

  // One clock: check DUT against the model, then advance the model across the edge.
  task automatic tick(output int g);
    int cap;
    bit slot, full;
    bit el[N];
    logic [N-1:0] er;
    logic [N*OB-1:0] ec;
    logic [LB+1:0] head;
    #1;
    cap  = cfg_max_out == 0 ? 15 : int'(cfg_max_out);
    slot = !mv || m_req_ready;
    full = mq.size() == D;
    for (int c = 0; c < N; c++)
      el[c] = s_req_valid[c] && wgt(c) != 0 && mcnt[c] < cap && !full && slot;
    g = -1;
    if (el[mptr] && mcred > 0) g = mptr;
    else for (int i = 1; i <= N; i++) if (g < 0 && el[(mptr + i) % N]) g = (mptr + i) % N;
    er = g < 0 ? '0 : N'(1 << g);
    for (int c = 0; c < N; c++) ec[c*OB +: OB] = OB'(mcnt[c]);
    head = mq.size() > 0 ? mq[0] : '0;
    chk("s_req_ready", s_req_ready, er);
    chk("m_req_valid", m_req_valid, mv);
    chk("m_req_data", m_req_data, md);
    chk("m_mux_valid", m_mux_valid, mq.size() > 0);
    chk("m_mux_id", m_mux_id, head[LB+1:LB]);
    chk("m_mux_len", m_mux_len, head[LB-1:0]);
    chk("out_cnt", out_cnt, ec);
    chk("err_underflow", err_underflow, merr);
    @(posedge aclk);
    if (mq.size() > 0 && m_mux_ready) void'(mq.pop_front());
    if (g >= 0) begin
      if (g == mptr && mcred > 0) mcred--;
      else begin mptr = g; mcred = wgt(g) - 1; end
      md = s_req_data[g*RB +: RB];
      mv = 1;
      mq.push_back({2'(g), s_req_len[g*LB +: LB]});
    end else if (m_req_ready) mv = 0;
    for (int c = 0; c < N; c++) begin
      bit inc, dec;
      inc = g == c;
      dec = s_done_valid && int'(s_done_id) == c;
      if (inc && !dec) mcnt[c]++;
      else if (dec && !inc) begin
        if (mcnt[c] == 0) merr = 1; else mcnt[c]--;
      end
    end
    @(negedge aclk);
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_m_req_data", m_req_data, 0);
    chk("rst_m_mux_valid", m_mux_valid, 0);
    chk("rst_m_mux_id", m_mux_id, 0);
    chk("rst_m_mux_len", m_mux_len, 0);
    chk("rst_s_req_ready", s_req_ready, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_err", err_underflow, 0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    int g, n;
    int exp1[12] = '{0, 1, 1, 2, 2, 2, 0, 1, 1, 2, 2, 2};
    logic [RB-1:0] d1;
    model_reset();
    @(negedge aclk);
    do_reset();

    cfg_weight = {4'd0, 4'd3, 4'd2, 4'd1}; cfg_max_out = 4'd15;
    s_req_valid = 4'hF; m_req_ready = 1'b1; m_mux_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_data();
      tick(g);
      chk("wrr_seq", g, exp1[i]);
    end

    do_reset();
    cfg_weight = 16'h1111; cfg_max_out = 4'd2; s_req_valid = 4'h1;
    n = 0;
    repeat (5) begin rand_data(); tick(g); if (g == 0) n++; end
    chk("cap_grants", n, 2);
    chk("cap_ready_low", s_req_ready, 0);
    s_done_valid = 1'b1; s_done_id = 2'd0;
    tick(g);
    s_done_valid = 1'b0;
    n = g == 0 ? 1 : 0;
    repeat (4) begin tick(g); if (g == 0) n++; end
    chk("cap_after_done", n, 1);

    do_reset();
    cfg_weight = 16'h1111; cfg_max_out = 4'd0; s_req_valid = 4'h2; m_req_ready = 1'b0;
    n = 0; d1 = '0;
    repeat (6) begin
      rand_data();
      tick(g);
      if (g == 1) begin n++; d1 = s_req_data[RB +: RB]; end
    end
    chk("stall_grants", n, 1);
    chk("stall_valid", m_req_valid, 1);
    chk("stall_data", m_req_data, d1);
    m_req_ready = 1'b1;
    tick(g);
    chk("stall_resume", g, 1);

    do_reset();
    cfg_weight = 16'h1111; s_req_valid = 4'hF; m_mux_ready = 1'b0;
    n = 0;
    repeat (20) begin rand_data(); tick(g); if (g >= 0) n++; end
    chk("fifo_fill", n, 16);
    chk("fifo_full_ready", s_req_ready, 0);
    m_mux_ready = 1'b1;
    tick(g);
    m_mux_ready = 1'b0;
    n = g >= 0 ? 1 : 0;
    repeat (3) begin tick(g); if (g >= 0) n++; end
    chk("fifo_one_pop", n, 1);

    do_reset();
    m_mux_ready = 1'b1; s_req_valid = 4'h4;
    tick(g);
    s_req_valid = 4'h0;
    chk("cnt2_one", out_cnt[11:8], 1);
    s_req_valid = 4'h4; s_done_valid = 1'b1; s_done_id = 2'd2;
    tick(g);
    chk("same_cycle_grant", g, 2);
    s_req_valid = 4'h0; s_done_id = 2'd1;
    chk("same_cycle_cnt", out_cnt[11:8], 1);
    tick(g);
    s_done_valid = 1'b0;
    chk("underflow_flag", err_underflow, 1);
    chk("underflow_cnt", out_cnt[7:4], 0);

    do_reset();
    s_req_valid = 4'hF; m_mux_ready = 1'b0;
    repeat (8) begin rand_data(); tick(g); end
    chk("mid_valid", m_req_valid, 1);
    do_reset();
    s_req_valid = 4'b1010;
    tick(g);
    chk("post_reset_first", g, 1);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        cfg_weight  = 16'($urandom);
        cfg_max_out = 4'($urandom_range(0, 15));
      end
      s_req_valid  = 4'($urandom);
      m_req_ready  = $urandom_range(0, 3) != 0;
      m_mux_ready  = $urandom_range(0, 2) != 0;
      s_done_valid = $urandom_range(0, 2) == 0;
      s_done_id    = 2'($urandom);
      rand_data();
      tick(g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
